seg_scan_driver: RTL and testbench

Downstream consumer of the 4-bit one-hot ring counter. Takes the rotating one-hot `phase` as digit-select for a 4-digit multiplexed seven-segment display. It double-buffers a 16-bit hex value through a valid/ready write port and commits it only at frame boundaries, so the display never tears. It also inserts anti-ghosting dead time on every phase change and flags non-one-hot phase input.

---
 rtl/seg_scan_pkg.sv | 33 +++
 rtl/seg_scan_driver_hex7seg.sv | 15 +
 rtl/seg_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
//   Shared constants for the multiplexed seven-segment scan driver:
//   digit count, segment width, the active-high hex glyph table and
//   the active-high blank pattern.
//   Segment bit order everywhere is {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK_AH = 7'b0000000;

  // Standard hex glyphs, active-high, indexed by nibble value.
  localparam logic [SEG_W-1:0] HEX_SEG_AH [16] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// hex7seg
//   Combinational hex nibble to seven-segment decoder, active-high.
//   Ports:
//     nibble  in  4  hex digit value
//     seg_ah  out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_ah
);

  assign seg_ah = HEX_SEG_AH[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Drives a 4-digit multiplexed seven-segment display from a rotating
//   one-hot phase. A 16-bit value is accepted over a valid/ready port into
//   a staging buffer and committed to the display buffer only on a frame
//   boundary (phase entering 4'b0001), so a frame never mixes two values.
//   Every phase change blanks the display for DEAD_CYCLES cycles to avoid
//   ghosting; a non-one-hot phase blanks the display and sets a sticky error.
//   Ports:
//     clk         in  1   clock
//     rst         in  1   synchronous reset, active-low
//     phase       in  4   one-hot digit select (bit0 = digit 0 = wr_data[3:0])
//     wr_valid    in  1   write request
//     wr_data     in  16  four hex nibbles
//     wr_ready    out 1   staging buffer free
//     err_clr     in  1   clears phase_err (a simultaneous set wins)
//     an          out 4   digit enables, active-high, registered
//     seg         out 7   segments {g,f,e,d,c,b,a}, registered
//     frame_tick  out 1   one-cycle pulse after each frame boundary
//     phase_err   out 1   sticky invalid-phase flag
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     phase,
  input  logic                  wr_valid,
  input  logic [4*DIGITS-1:0]   wr_data,
  output logic                  wr_ready,
  input  logic                  err_clr,
  output logic [DIGITS-1:0]     an,
  output logic [SEG_W-1:0]      seg,
  output logic                  frame_tick,
  output logic                  phase_err
);

  // The change edge itself is the first blank cycle, so the counter is
  // loaded with one less than the requested dead time. This gives the
  // new digit on the (DEAD_CYCLES+1)-th edge after the phase change.
  localparam logic [3:0] DEAD_RELOAD =
    (DEAD_CYCLES > 0) ? 4'(DEAD_CYCLES - 1) : 4'd0;

  localparam logic [SEG_W-1:0] SEG_BLANK =
    SEG_ACTIVE_LOW ? ~SEG_BLANK_AH : SEG_BLANK_AH;

  logic [4*DIGITS-1:0] staging;
  logic [4*DIGITS-1:0] display;
  logic                pending;
  logic [DIGITS-1:0]   phase_q;
  logic [3:0]          dead_cnt;

  logic                phase_change;
  logic                phase_valid;
  logic                frame_boundary;
  logic [3:0]          sel_nib;
  logic [SEG_W-1:0]    dec_ah;
  logic [SEG_W-1:0]    seg_lit;

  assign phase_change   = (phase != phase_q);
  assign phase_valid    = $onehot(phase);
  assign frame_boundary = phase_change && (phase == 4'b0001);

  assign wr_ready = rst && !pending;

  // Digit selection uses the live phase: outside a change edge it equals
  // phase_q, and with zero dead time it lets the new digit show on the
  // change edge itself.
  // NOTE: every combinational output gets a default before the case so no
  // latch is inferred for unmatched (non-one-hot) phase values.
  always_comb begin
    sel_nib = display[3:0];
    case (phase)
      4'b0010: sel_nib = display[7:4];
      4'b0100: sel_nib = display[11:8];
      4'b1000: sel_nib = display[15:12];
      default: sel_nib = display[3:0];
    endcase
  end

  hex7seg u_hex7seg (
    .nibble (sel_nib),
    .seg_ah (dec_ah)
  );

  assign seg_lit = SEG_ACTIVE_LOW ? ~dec_ah : dec_ah;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      staging    <= '0;
      display    <= '0;
      pending    <= 1'b0;
      phase_q    <= '0;
      dead_cnt   <= '0;
      an         <= '0;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
      phase_err  <= 1'b0;
    end else begin
      phase_q    <= phase;
      frame_tick <= frame_boundary;

      // Commit and accept are mutually exclusive: accept needs pending == 0
      // and commit needs pending == 1. A word accepted on a boundary edge
      // therefore waits for the following boundary.
      if (frame_boundary && pending) begin
        display <= staging;
        pending <= 1'b0;
      end else if (wr_valid && wr_ready) begin
        staging <= wr_data;
        pending <= 1'b1;
      end

      if (!phase_valid) begin
        an        <= '0;
        seg       <= SEG_BLANK;
        dead_cnt  <= '0;
        phase_err <= 1'b1;
      end else begin
        if (err_clr) begin
          phase_err <= 1'b0;
        end
        if (phase_change && (DEAD_CYCLES != 0)) begin
          dead_cnt <= DEAD_RELOAD;
          an       <= '0;
          seg      <= SEG_BLANK;
        end else if (!phase_change && (dead_cnt != 4'd0)) begin
          dead_cnt <= dead_cnt - 4'd1;
          an       <= '0;
          seg      <= SEG_BLANK;
        end else begin
          an  <= phase;
          seg <= seg_lit;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
//   Directed bench for seg_scan_driver. Main instance uses the defaults
//   (DEAD_CYCLES = 2, active-low segments); a second instance with
//   DEAD_CYCLES = 0 shares the inputs and is checked only in the
//   zero-dead-time scenario.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  phase;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        err_clr;

  logic        wr_ready, frame_tick, phase_err;
  logic [3:0]  an;
  logic [6:0]  seg;

  logic        wr_ready0, frame_tick0, phase_err0;
  logic [3:0]  an0;
  logic [6:0]  seg0;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [6:0] BLANK_AL = 7'b1111111;

  always #5 clk = ~clk;

  seg_scan_driver u_dut (
    .clk(clk), .rst(rst), .phase(phase), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .err_clr(err_clr),
    .an(an), .seg(seg), .frame_tick(frame_tick), .phase_err(phase_err)
  );

  seg_scan_driver #(.DEAD_CYCLES(0), .SEG_ACTIVE_LOW(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .phase(phase), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready0), .err_clr(err_clr),
    .an(an0), .seg(seg0), .frame_tick(frame_tick0), .phase_err(phase_err0)
  );

  // Hand-written active-low glyphs, {g,f,e,d,c,b,a}, 0 = lit.
  function automatic logic [6:0] al(input logic [3:0] nib);
    case (nib)
      4'h0: al = 7'b1000000;
      4'h1: al = 7'b1111001;
      4'h2: al = 7'b0100100;
      4'h3: al = 7'b0110000;
      4'h4: al = 7'b0011001;
      4'h8: al = 7'b0000000;
      4'hA: al = 7'b0001000;
      4'hF: al = 7'b0001110;
      default: al = 7'bxxxxxxx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to a new valid phase and follow it through the two blank cycles
  // to the displayed digit.
  task automatic visit(input logic [3:0] p, input logic [3:0] nib,
                       input logic exp_rdy);
    phase = p;
    step();
    check("tick", {15'd0, frame_tick}, {15'd0, p == 4'b0001});
    check("ready", {15'd0, wr_ready}, {15'd0, exp_rdy});
    check("dead1_an", {12'd0, an}, 16'd0);
    check("dead1_seg", {9'd0, seg}, {9'd0, BLANK_AL});
    step();
    check("dead2_an", {12'd0, an}, 16'd0);
    check("dead2_tick", {15'd0, frame_tick}, 16'd0);
    step();
    check("digit_an", {12'd0, an}, {12'd0, p});
    check("digit_seg", {9'd0, seg}, {9'd0, al(nib)});
  endtask

  initial begin
    rst = 1'b0; phase = 4'b0001; wr_valid = 1'b0; wr_data = '0; err_clr = 1'b0;

    // 1. reset, write, commit
    step(); step();
    check("rst_an", {12'd0, an}, 16'd0);
    check("rst_seg", {9'd0, seg}, {9'd0, BLANK_AL});
    check("rst_tick", {15'd0, frame_tick}, 16'd0);
    check("rst_err", {15'd0, phase_err}, 16'd0);
    check("rst_ready", {15'd0, wr_ready}, 16'd0);
    rst = 1'b1;
    #1;
    check("ready_out_of_rst", {15'd0, wr_ready}, 16'd1);
    step();
    check("first_tick", {15'd0, frame_tick}, 16'd1);
    check("first_dead_an", {12'd0, an}, 16'd0);
    step();
    check("first_dead2_an", {12'd0, an}, 16'd0);
    step();
    check("first_an", {12'd0, an}, 16'd1);
    check("first_seg", {9'd0, seg}, {9'd0, al(4'h0)});
    wr_valid = 1'b1; wr_data = 16'h1234;
    step();
    wr_valid = 1'b0;
    check("accept_ready", {15'd0, wr_ready}, 16'd0);
    visit(4'b0010, 4'h0, 1'b0);
    visit(4'b0100, 4'h0, 1'b0);
    visit(4'b1000, 4'h0, 1'b0);
    visit(4'b0001, 4'h4, 1'b1);
    visit(4'b0010, 4'h3, 1'b1);
    visit(4'b0100, 4'h2, 1'b1);
    visit(4'b1000, 4'h1, 1'b1);

    // 2. tearing: second write while busy is refused
    wr_valid = 1'b1; wr_data = 16'hAAAA;
    step();
    wr_data = 16'h8888;
    check("busy_ready", {15'd0, wr_ready}, 16'd0);
    step();
    check("busy_ready2", {15'd0, wr_ready}, 16'd0);
    wr_valid = 1'b0;
    check("old_digit_an", {12'd0, an}, 16'b1000);
    check("old_digit_seg", {9'd0, seg}, {9'd0, al(4'h1)});
    visit(4'b0001, 4'hA, 1'b1);
    visit(4'b0010, 4'hA, 1'b1);
    visit(4'b0100, 4'hA, 1'b1);
    visit(4'b1000, 4'hA, 1'b1);
    visit(4'b0001, 4'hA, 1'b1);

    // 3. invalid phase
    phase = 4'b0011;
    step();
    check("inv_an", {12'd0, an}, 16'd0);
    check("inv_seg", {9'd0, seg}, {9'd0, BLANK_AL});
    check("inv_err", {15'd0, phase_err}, 16'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_vs_set", {15'd0, phase_err}, 16'd1);
    visit(4'b0100, 4'hA, 1'b1);
    check("err_sticky", {15'd0, phase_err}, 16'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_cleared", {15'd0, phase_err}, 16'd0);
    phase = 4'b0000;
    step();
    check("zero_err", {15'd0, phase_err}, 16'd1);
    check("zero_an", {12'd0, an}, 16'd0);
    phase = 4'b0100;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("zero_err_clr", {15'd0, phase_err}, 16'd0);

    // 4. zero dead time: an follows phase one edge later, never blank
    foreach (rot4[i]) begin
      phase = rot4[i];
      step();
      check("d0_an", {12'd0, an0}, {12'd0, rot4[i]});
      check("d0_tick", {15'd0, frame_tick0}, {15'd0, rot4[i] == 4'b0001});
    end

    // 5. reset with a staged word
    step(); step(); step();
    check("pre_rst_an", {12'd0, an}, 16'b0100);
    wr_valid = 1'b1; wr_data = 16'h5678;
    step();
    wr_valid = 1'b0;
    check("staged_ready", {15'd0, wr_ready}, 16'd0);
    rst = 1'b0;
    step();
    check("mid_rst_an", {12'd0, an}, 16'd0);
    check("mid_rst_seg", {9'd0, seg}, {9'd0, BLANK_AL});
    rst = 1'b1;
    #1;
    check("post_rst_ready", {15'd0, wr_ready}, 16'd1);
    step();
    check("post_rst_dead1", {12'd0, an}, 16'd0);
    step();
    check("post_rst_dead2", {12'd0, an}, 16'd0);
    step();
    check("post_rst_an", {12'd0, an}, 16'b0100);
    check("post_rst_seg", {9'd0, seg}, {9'd0, al(4'h0)});
    visit(4'b1000, 4'h0, 1'b1);
    visit(4'b0001, 4'h0, 1'b1);
    visit(4'b0010, 4'h0, 1'b1);
    visit(4'b0100, 4'h0, 1'b1);
    visit(4'b1000, 4'h0, 1'b1);

    // 6. accept on the boundary edge waits one frame
    phase = 4'b0001; wr_valid = 1'b1; wr_data = 16'hF0F0;
    step();
    wr_valid = 1'b0;
    check("sim_tick", {15'd0, frame_tick}, 16'd1);
    check("sim_ready", {15'd0, wr_ready}, 16'd0);
    step(); step();
    check("sim_an", {12'd0, an}, 16'd1);
    check("sim_seg", {9'd0, seg}, {9'd0, al(4'h0)});
    visit(4'b0010, 4'h0, 1'b0);
    visit(4'b0100, 4'h0, 1'b0);
    visit(4'b1000, 4'h0, 1'b0);
    visit(4'b0001, 4'h0, 1'b1);
    visit(4'b0010, 4'hF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  logic [3:0] rot4 [8] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100,
                           4'b1000, 4'b0001, 4'b0010, 4'b0100};

endmodule
